// File: rtl/mem_arb_pkg.sv
// Shared encodings for the mem_port_arbiter slice: FSM states, requester IDs,
// default starvation limit and the alignment helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam int STARVE_MAX_DEF = 4;

  // A word access is misaligned when either low byte-address bit is set.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |addr_lo;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// Instantiated by mem_port_arbiter only when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int            CW    = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port mem between fetch (IF) and data (D) requesters.
// Define MEM_ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_err,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_err,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_read,
  output logic          o_mem_write,
  input  logic [DW-1:0] i_mem_rdata
);

  arb_state_t    r_state;
  req_id_t       r_id;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_mis;
  logic          r_if_gnt, r_d_gnt;
  logic          r_if_rvalid, r_d_rvalid;
  logic          r_if_err, r_d_err;
  logic [DW-1:0] r_if_rdata, r_d_rdata;
  logic          r_mem_read, r_mem_write;

  logic          w_any_req;
  logic          w_pick_if;
  logic          w_starve_sat;
  logic [AW-1:0] w_sel_addr;
  logic          w_sel_we;
  logic          w_sel_mis;

  assign w_any_req = i_if_req | i_d_req;

  // NOTE: combinational decode gives every output a default before any branch,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_pick_if = 1'b0;
    if (i_if_req && (!i_d_req || w_starve_sat)) begin
      w_pick_if = 1'b1;
    end
  end

  assign w_sel_addr = w_pick_if ? i_if_addr : i_d_addr;
  assign w_sel_we   = !w_pick_if && i_d_we;
  assign w_sel_mis  = is_misaligned(w_sel_addr[1:0]);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic w_idle;
  logic w_starve_inc;
  logic w_starve_clr;

  assign w_idle       = (r_state == IDLE);
  assign w_starve_inc = w_idle && i_d_req && !w_pick_if && i_if_req;
  assign w_starve_clr = w_idle && (!i_if_req || w_pick_if);

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_starve_inc),
    .i_clr   (w_starve_clr),
    .o_sat   (w_starve_sat)
  );
`else
  logic w_unused_starve;
  assign w_unused_starve = (STARVE_MAX == 0);
  assign w_starve_sat    = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_id        <= REQ_IF;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_mis       <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_err     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_err     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_id        <= w_pick_if ? REQ_IF : REQ_D;
            r_addr      <= w_sel_addr;
            r_we        <= w_sel_we;
            r_mis       <= w_sel_mis;
            r_if_gnt    <= w_pick_if;
            r_d_gnt     <= !w_pick_if;
            r_mem_read  <= !w_sel_we && !w_sel_mis;
            r_mem_write <= w_sel_we && !w_sel_mis;
            if (!w_pick_if) begin
              r_wdata <= i_d_wdata;
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          // mem reads combinationally, so the word is valid at this edge.
          if (r_id == REQ_D) begin
            r_d_rvalid <= 1'b1;
            r_d_err    <= r_mis;
            if (r_mis) begin
              r_d_rdata <= '0;
            end else if (!r_we) begin
              r_d_rdata <= i_mem_rdata;
            end
          end else begin
            r_if_rvalid <= 1'b1;
            r_if_err    <= r_mis;
            r_if_rdata  <= r_mis ? '0 : i_mem_rdata;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_if_gnt    = r_if_gnt;
  assign o_d_gnt     = r_d_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_if_err    = r_if_err;
  assign o_d_err     = r_d_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_read  = r_mem_read;
  // Reset must block a store already sitting in ACCESS from reaching mem.
  assign o_mem_write = r_mem_write && !i_reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word-addressed mem model on its port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:255];
  logic        tb_we;
  logic [7:0]  tb_idx;
  logic [31:0] tb_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_gnt    (if_gnt),
    .o_if_rvalid (if_rvalid),
    .o_if_rdata  (if_rdata),
    .o_if_err    (if_err),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .o_d_gnt     (d_gnt),
    .o_d_rvalid  (d_rvalid),
    .o_d_rdata   (d_rdata),
    .o_d_err     (d_err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .i_mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    else if (tb_we) mem[tb_idx] <= tb_data;
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    tb_idx  = addr[9:2];
    tb_data = data;
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".if_gnt"},    if_gnt,    0);
    check({tag, ".d_gnt"},     d_gnt,     0);
    check({tag, ".if_rvalid"}, if_rvalid, 0);
    check({tag, ".d_rvalid"},  d_rvalid,  0);
    check({tag, ".if_err"},    if_err,    0);
    check({tag, ".d_err"},     d_err,     0);
    check({tag, ".if_rdata"},  if_rdata,  0);
    check({tag, ".d_rdata"},   d_rdata,   0);
    check({tag, ".mem_addr"},  mem_addr,  0);
    check({tag, ".mem_wdata"}, mem_wdata, 0);
    check({tag, ".mem_read"},  mem_read,  0);
    check({tag, ".mem_write"}, mem_write, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d_before, d_after, if_cnt;
    reset = 1'b1; tb_we = 1'b0; tb_idx = '0; tb_data = '0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    preload(32'h28,  32'h00A00093);
    preload(32'h2C,  32'h11112222);
    preload(32'h100, 32'h00000000);
    preload(32'h104, 32'h33334444);
    preload(32'h108, 32'hA5A5A5A5);
    check_zero("rst");
    reset = 1'b0;

    // Single fetch
    if_req = 1'b1; if_addr = 32'h28;
    @(negedge clk);
    check("fetch.gnt",      if_gnt,    1);
    check("fetch.d_gnt",    d_gnt,     0);
    check("fetch.mem_read", mem_read,  1);
    check("fetch.mem_wr",   mem_write, 0);
    check("fetch.mem_addr", mem_addr,  32'h28);
    check("fetch.rv_early", if_rvalid, 0);
    if_req = 1'b0;
    @(negedge clk);
    check("fetch.rvalid",   if_rvalid, 1);
    check("fetch.rdata",    if_rdata,  32'h00A00093);
    check("fetch.err",      if_err,    0);
    check("fetch.gnt_off",  if_gnt,    0);
    check("fetch.rd_off",   mem_read,  0);
    @(negedge clk);
    check("fetch.rv_off",   if_rvalid, 0);

    // Store then load
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("st.gnt",       d_gnt,     1);
    check("st.mem_write", mem_write, 1);
    check("st.mem_read",  mem_read,  0);
    check("st.mem_wdata", mem_wdata, 32'hDEADBEEF);
    d_req = 1'b0;
    @(negedge clk);
    check("st.rvalid",    d_rvalid,  1);
    check("st.err",       d_err,     0);
    check("st.wr_once",   mem_write, 0);
    check("st.mem",       mem[64],   32'hDEADBEEF);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    check("ld.gnt",       d_gnt,     1);
    check("ld.mem_read",  mem_read,  1);
    d_req = 1'b0;
    @(negedge clk);
    check("ld.rvalid",    d_rvalid,  1);
    check("ld.rdata",     d_rdata,   32'hDEADBEEF);
    @(negedge clk);

    // Collision: D wins, IF served from the next IDLE
    if_req = 1'b1; if_addr = 32'h2C;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    @(negedge clk);
    check("col.d_gnt",    d_gnt,     1);
    check("col.if_gnt0",  if_gnt,    0);
    d_req = 1'b0;
    @(negedge clk);
    check("col.d_rvalid", d_rvalid,  1);
    check("col.d_rdata",  d_rdata,   32'h33334444);
    check("col.if_gnt1",  if_gnt,    0);
    @(negedge clk);
    check("col.if_gnt2",  if_gnt,    0);
    @(negedge clk);
    check("col.if_gnt",   if_gnt,    1);
    check("col.mem_addr", mem_addr,  32'h2C);
    if_req = 1'b0;
    @(negedge clk);
    check("col.if_rvalid", if_rvalid, 1);
    check("col.if_rdata",  if_rdata,  32'h11112222);
    @(negedge clk);

    // Misaligned store never touches mem
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h102; d_wdata = 32'h55555555;
    @(negedge clk);
    check("mis.gnt",       d_gnt,     1);
    check("mis.mem_write", mem_write, 0);
    check("mis.mem_read",  mem_read,  0);
    d_req = 1'b0;
    @(negedge clk);
    check("mis.rvalid",    d_rvalid,  1);
    check("mis.err",       d_err,     1);
    check("mis.rdata",     d_rdata,   0);
    check("mis.wr_resp",   mem_write, 0);
    check("mis.mem",       mem[64],   32'hDEADBEEF);
    @(negedge clk);

    // Both requesters held high continuously
    d_before = 0; d_after = 0; if_cnt = 0;
    if_req = 1'b1; if_addr = 32'h28;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (if_gnt) if_cnt++;
      if (d_gnt) begin
        if (if_cnt == 0) d_before++;
        else d_after++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve.d_before", d_before, 4);
    check("starve.if_gnts",  if_cnt,   1);
    check("starve.d_after",  d_after,  3);
`else
    check("starve.d_before", d_before, 8);
    check("starve.if_gnts",  if_cnt,   0);
`endif
    @(negedge clk);

    // Reset while a store sits in ACCESS
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h108; d_wdata = 32'h12345678;
    @(negedge clk);
    check("rsta.gnt",      d_gnt,     1);
    check("rsta.wr_pre",   mem_write, 1);
    d_req = 1'b0;
    reset = 1'b1;
    #1;
    check("rsta.wr_gated", mem_write, 0);
    @(negedge clk);
    check_zero("rsta");
    check("rsta.mem",      mem[66],   32'hA5A5A5A5);
    reset = 1'b0;
    @(negedge clk);
    check("rsta.no_rv1",   d_rvalid,  0);
    @(negedge clk);
    check("rsta.no_rv2",   d_rvalid,  0);
    check("rsta.mem2",     mem[66],   32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port `mem` block between two requesters: instruction fetch (IF) and data load/store (D).
- Provides a registered two-phase valid/grant handshake, fixed data-over-fetch priority and an optional fetch starvation guard.
- Sits between the fetch/execute control and the `mem` instance, and drives its address, memIn, read and write pins.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive D grants with IF pending before IF is forced to win (guard build only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch byte address.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata/if_err valid.
- if_rdata  out  DW  fetched word.
- if_err  out  1  misaligned fetch, qualified by if_rvalid.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- d_rdata  out  DW  load data; undefined for stores.
- d_err  out  1  misaligned data access, qualified by d_rvalid.
- mem_addr  out  AW  to mem address.
- mem_wdata  out  DW  to mem memIn.
- mem_read  out  1  to mem read.
- mem_write  out  1  to mem write; mem writes on clk edge.
- mem_rdata  in  DW  from mem memOut; combinational read.

Behaviour:
- States: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick the winner, latch its addr/wdata/we/id and misalign flag (addr[1:0]!=0), then go to ACCESS. Otherwise stay in IDLE.
- Winner: D if d_req, else IF. With the guard build, IF wins when if_req and the starvation count equals STARVE_MAX.
- ACCESS, one cycle:
  - winner's gnt = 1.
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_read = !we & !misalign; mem_write = we & !misalign & !reset.
  - At the edge, mem_rdata is captured into the winner's rdata register (loads only); go to RESP.
- RESP, one cycle: winner's rvalid = 1 and err = misalign flag; next state IDLE.
- Latency: req seen at cycle N, gnt in N+1, rvalid in N+2. Peak throughput is one access per 3 cycles.
- A requester must drop req in the cycle after gnt. A req still high in IDLE is a new request.
- Simultaneous requests: one is granted. The loser's req stays pending and is served from the next IDLE.
- Misaligned access: mem_read and mem_write stay 0 for the whole access, so mem is never touched. rvalid still pulses, with err = 1 and rdata = 0.
- Outside their state, mem_read, mem_write, gnt and rvalid are 0. mem_addr and mem_wdata hold their last latched values.
- rdata registers hold their value until the next load or misaligned response for that port.
- Reset (any state): next state IDLE; latched addr/wdata/rdata = 0; starve count = 0. All outputs read 0 the cycle after reset.
- mem_write is gated by reset, so a store caught in ACCESS during reset is not written.
- An in-flight response is discarded at reset; no rvalid is issued for it.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - The starve counter increments on each D grant made while if_req is high. It saturates at STARVE_MAX.
  - It clears on any IF grant, or when if_req is low in IDLE.
  - At STARVE_MAX, a pending IF wins over D.
- Undefined: strict D priority, so IF may starve indefinitely. The counter logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  - requester IDs REQ_IF = 1'b0, REQ_D = 1'b1;
  - default STARVE_MAX.
- One sub-module, arb_starve_ctr: saturating counter with inc/clr/sat. Instantiated only under MEM_ARB_STARVE_GUARD_EN.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x28; mem[0x28] = 0x00A00093 → if_gnt at N+1, mem_read = 1 with mem_addr = 0x28 in N+1, if_rvalid with if_rdata = 0x00A00093 at N+2, if_err = 0.
- Store then load: d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, then d_we = 0, d_addr = 0x100 → mem_write pulses once, then d_rdata = 0xDEADBEEF with d_rvalid.
- Collision: if_req and d_req rise together (0x2C / 0x104) → d_gnt first, if_gnt at N+4; if_rdata = mem[0x2C].
- Misaligned: d_addr = 0x102, d_we = 1 → mem_write stays 0 throughout, d_rvalid with d_err = 1, mem[0x100] unchanged.
- Reset in ACCESS of a store to 0x108 → mem_write = 0 at that edge, mem[0x108] unchanged, no d_rvalid, all outputs 0 the next cycle.
- Guard build, STARVE_MAX = 4: d_req held high continuously with if_req high → exactly 4 D grants, then if_gnt, then D resumes. Without the macro, if_gnt never asserts.
